// File: rtl/datapath_ctrl.sv
// Instruction sequencer for the regfile/ALU datapath: fetch, decode and
// execute one 16-bit instruction every three cycles from a synchronous ROM.
module datapath_ctrl #(
   parameter int unsigned PC_W     = 8,
   parameter int unsigned RESET_PC = 0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   output logic [PC_W-1:0] instr_addr,
   input  logic [15:0]     instr_data,
   input  logic            alu_zero,
   input  logic            alu_carry,
   output logic [2:0]      alu_opcode,
   output logic            alu_en,
   output logic [3:0]      ra_addr,
   output logic [3:0]      rb_addr,
   output logic [3:0]      write_addr,
   output logic [7:0]      user_write_data,
   output logic            write_en,
   output logic            zero_flag,
   output logic            carry_flag,
   output logic            busy,
   output logic            halted
);

   localparam logic [PC_W-1:0] RST_PC = PC_W'(RESET_PC);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_HALT
   } state_t;

   state_t          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [15:0]     ir_q, ir_d;
   logic            zero_q, zero_d;
   logic            carry_q, carry_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         pc_q    <= RST_PC;
         ir_q    <= '0;
         zero_q  <= 1'b0;
         carry_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         zero_q  <= zero_d;
         carry_q <= carry_d;
      end
   end

   // Write strobes are decoded from registered state only, so reset drops them at once.
   always_comb begin
      state_d         = state_q;
      pc_d            = pc_q;
      ir_d            = ir_q;
      zero_d          = zero_q;
      carry_d         = carry_q;
      alu_opcode      = '0;
      alu_en          = 1'b0;
      ra_addr         = '0;
      rb_addr         = '0;
      write_addr      = '0;
      user_write_data = '0;
      write_en        = 1'b0;

      case (state_q)
         S_IDLE, S_HALT: begin
            if (start) begin
               state_d = S_FETCH;
               pc_d    = RST_PC;
               zero_d  = 1'b0;
               carry_d = 1'b0;
            end
         end
         S_FETCH: state_d = S_DECODE;
         S_DECODE: begin
            ir_d    = instr_data;
            state_d = S_EXEC;
         end
         S_EXEC: begin
            alu_opcode = ir_q[14:12];
            ra_addr    = ir_q[7:4];
            rb_addr    = ir_q[3:0];
            state_d    = S_FETCH;
            pc_d       = pc_q + PC_W'(1);
            if (!ir_q[15]) begin
               write_addr = ir_q[11:8];
               alu_en     = 1'b1;
               write_en   = 1'b1;
               zero_d     = alu_zero;
               carry_d    = alu_carry;
            end else begin
               case (ir_q[14:12])
                  3'b000: begin
                     write_addr      = ir_q[11:8];
                     user_write_data = ir_q[7:0];
                     write_en        = 1'b1;
                  end
                  3'b001: pc_d = ir_q[PC_W-1:0];
                  3'b010: if (zero_q)  pc_d = ir_q[PC_W-1:0];
                  3'b011: if (carry_q) pc_d = ir_q[PC_W-1:0];
                  3'b111: begin
                     pc_d    = pc_q;
                     state_d = S_HALT;
                  end
                  default: ;
               endcase
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign instr_addr = pc_q;
   assign zero_flag  = zero_q;
   assign carry_flag = carry_q;
   assign busy       = (state_q == S_FETCH) || (state_q == S_DECODE) || (state_q == S_EXEC);
   assign halted     = (state_q == S_HALT);

endmodule
